// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit frame feeder.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } feed_state_t;

    localparam logic [3:0] MIN_LEN = 4'd5;
    localparam logic [3:0] MAX_LEN = 4'd8;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        logic [3:0] r;
        r = len;
        if (len < MIN_LEN) r = MIN_LEN;
        if (len > MAX_LEN) r = MAX_LEN;
        return r;
    endfunction

    function automatic parity_t map_parity(input logic [1:0] ptype);
        parity_t r;
        case (ptype)
            2'd1:    r = PAR_ODD;
            2'd2:    r = PAR_EVEN;
            default: r = PAR_NONE;
        endcase
        return r;
    endfunction

    // Ones in the low len bits; len is already clamped to 5..8.
    function automatic logic [7:0] len_mask(input logic [3:0] len);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (4'(i) < len);
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the frame FSM; full/empty come straight from the occupancy count.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] push_data,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_frame_feeder.sv
// Frame feeder ahead of the UART shifter: queues host bytes, latches per-frame config
// and parity, pulses send, then holds off for the frame's duration on the baud clock.
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued byte
//   LOAD  | pop head, sample cfg, register data/parity/length/type
//   SEND  | one-cycle send pulse, wait counter loaded with frame length
//   WAIT  | shifter clocking the frame out; counts down W cycles
module uart_tx_frame_feeder
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int IDLE_GAP   = 0
) (
    input  logic       baud_clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] cfg_data_length,
    input  logic [1:0] cfg_parity_type,
    output logic [7:0] data,
    output logic       parity_bit,
    output logic [3:0] data_length,
    output logic [1:0] parity_type,
    output logic       send,
    output logic       busy
);
    // Start bit plus stop bits plus gap; data and parity bits are added per frame.
    localparam logic [4:0] W_BASE = 5'(1 + STOP_BITS + IDLE_GAP);

    feed_state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic [3:0]  len_q, len_d;
    parity_t     ptype_q, ptype_d;

    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [3:0]  len_c;
    parity_t     ptype_c;
    logic [7:0]  masked_c;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (baud_clk),
        .rst       (reset),
        .push_data (in_data),
        .push      (in_valid),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign len_c    = clamp_len(cfg_data_length);
    assign ptype_c  = map_parity(cfg_parity_type);
    assign masked_c = fifo_head & len_mask(len_c);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        par_d    = par_q;
        len_d    = len_q;
        ptype_d  = ptype_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                data_d   = masked_c;
                len_d    = len_c;
                ptype_d  = ptype_c;
                case (ptype_c)
                    PAR_ODD:  par_d = ~^masked_c;
                    PAR_EVEN: par_d = ^masked_c;
                    default:  par_d = 1'b0;
                endcase
                state_d = ST_SEND;
            end
            ST_SEND: begin
                cnt_d   = W_BASE + {1'b0, len_q} + {4'b0000, ptype_q != PAR_NONE};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            len_q   <= MAX_LEN;
            ptype_q <= PAR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            len_q   <= len_d;
            ptype_q <= ptype_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign send        = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign data        = data_q;
    assign parity_bit  = par_q;
    assign data_length = len_q;
    assign parity_type = ptype_q;

endmodule
